// File: rtl/sar_pkg.sv
// sar_pkg: shared state encoding and default width for the sar_search controller
package sar_pkg;
  typedef enum logic [1:0] {IDLE, PROBE, VERIFY, DONE} state_t;
  localparam int SAR_WIDTH = 4;
endpackage

// File: rtl/sar_search.sv
// sar_search: binary search of a comparator's hidden operand via guess/flags (optional SAR_FLAG_CHECK_EN)
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_greater,
  input  logic             cmp_lesser,
  input  logic             cmp_equal,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] result,
  output logic             err
);
  localparam int IW = $clog2(WIDTH);
  state_t state, state_n;
  logic [WIDTH-1:0] guess_n, result_n, nxt, bit_mask;
  logic [IW-1:0] idx, idx_n;
  logic found_n, err_n, bad;
`ifdef SAR_FLAG_CHECK_EN
  assign bad = !$onehot({cmp_greater, cmp_lesser, cmp_equal});
`else
  logic unused_lesser;
  assign unused_lesser = cmp_lesser;
  assign bad = 1'b0;
`endif
  assign busy = (state == PROBE) || (state == VERIFY);
  assign done = state == DONE;
  always_comb begin
    state_n  = state;
    guess_n  = guess;
    idx_n    = idx;
    found_n  = found;
    result_n = result;
    err_n    = err;
    bit_mask = WIDTH'(1) << idx;
    nxt      = cmp_greater ? guess & ~bit_mask : guess;
    if ((state == IDLE || state == DONE) && start) begin
      guess_n = WIDTH'(1) << (WIDTH - 1);
      idx_n   = IW'(WIDTH - 1);
      found_n = 1'b0;
      err_n   = 1'b0;
      state_n = PROBE;
    end else if (busy) begin
      if (bad) begin
        err_n    = 1'b1;
        found_n  = 1'b0;
        result_n = guess;
        state_n  = DONE;
      end else if (state == VERIFY || cmp_equal) begin
        result_n = guess;
        found_n  = cmp_equal;
        state_n  = DONE;
      end else if (idx != '0) begin
        guess_n = nxt | (bit_mask >> 1);
        idx_n   = idx - 1'b1;
      end else begin
        guess_n = nxt;
        state_n = VERIFY;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      guess  <= '0;
      idx    <= '0;
      found  <= 1'b0;
      result <= '0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      guess  <= guess_n;
      idx    <= idx_n;
      found  <= found_n;
      result <= result_n;
      err    <= err_n;
    end
  end
endmodule

// File: tb/tb_sar_search.sv
// tb_sar_search: directed self-checking bench pairing sar_search with a behavioural comparator
module tb_sar_search;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic frc = 1'b0;
  logic [3:0] target = '0;
  logic cmp_greater, cmp_lesser, cmp_equal;
  logic [3:0] guess, result;
  logic busy, done, found, err;
  int checks = 0;
  int errors = 0;
  int cycles;
  logic [3:0] gs [0:15];
  always #5 clk = ~clk;
  assign cmp_greater = frc ? 1'b1 : guess > target;
  assign cmp_lesser  = frc ? 1'b0 : guess < target;
  assign cmp_equal   = frc ? 1'b1 : guess == target;
  sar_search #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_greater(cmp_greater), .cmp_lesser(cmp_lesser), .cmp_equal(cmp_equal),
    .guess(guess), .busy(busy), .done(done), .found(found), .result(result), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run(input logic [3:0] t, input int hold);
    target = t;
    start = 1'b1;
    @(negedge clk);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      chk("busy_hold", {31'd0, busy}, 32'd1);
    end
    start = 1'b0;
    cycles = hold - 1;
    gs[cycles] = guess;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (!done && cycles < 16) gs[cycles] = guess;
    end
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_guess", {28'd0, guess}, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_found", {31'd0, found}, 32'd0);
    chk("rst_result", {28'd0, result}, 32'h0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run(4'd0, 1);
    chk("t0_g1", {28'd0, gs[0]}, 32'h8);
    chk("t0_g2", {28'd0, gs[1]}, 32'h4);
    chk("t0_g3", {28'd0, gs[2]}, 32'h2);
    chk("t0_g4", {28'd0, gs[3]}, 32'h1);
    chk("t0_verify", {28'd0, gs[4]}, 32'h0);
    chk("t0_cycles", cycles, 5);
    chk("t0_found", {31'd0, found}, 32'd1);
    chk("t0_result", {28'd0, result}, 32'h0);
    run(4'd15, 1);
    chk("t15_g2", {28'd0, gs[1]}, 32'hc);
    chk("t15_g3", {28'd0, gs[2]}, 32'he);
    chk("t15_g4", {28'd0, gs[3]}, 32'hf);
    chk("t15_cycles", cycles, 4);
    chk("t15_found", {31'd0, found}, 32'd1);
    chk("t15_result", {28'd0, result}, 32'hf);
    run(4'd8, 1);
    chk("t8_cycles", cycles, 1);
    chk("t8_result", {28'd0, result}, 32'h8);
    chk("t8_found", {31'd0, found}, 32'd1);
    chk("t8_done_hold", {31'd0, done}, 32'd1);
    run(4'd5, 3);
    chk("t5_cycles", cycles, 4);
    chk("t5_result", {28'd0, result}, 32'h5);
    for (int t = 0; t < 16; t++) begin
      run(t[3:0], 1);
      chk("sweep_result", {28'd0, result}, t);
      chk("sweep_found", {31'd0, found}, 32'd1);
      chk("sweep_cycles_le5", {31'd0, cycles <= 5}, 32'd1);
    end
    target = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_guess", {28'd0, guess}, 32'h0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", {28'd0, result}, 32'h0);
    run(4'd3, 1);
    chk("after_rst_result", {28'd0, result}, 32'h3);
    chk("after_rst_cycles", cycles, 4);
    chk("after_rst_found", {31'd0, found}, 32'd1);
    target = 4'd10;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("frc_probe2_guess", {28'd0, guess}, 32'hc);
    frc = 1'b1;
    @(negedge clk);
    frc = 1'b0;
    chk("frc_done", {31'd0, done}, 32'd1);
    chk("frc_result", {28'd0, result}, 32'hc);
`ifdef SAR_FLAG_CHECK_EN
    chk("frc_err", {31'd0, err}, 32'd1);
    chk("frc_found", {31'd0, found}, 32'd0);
`else
    chk("frc_err", {31'd0, err}, 32'd0);
    chk("frc_found", {31'd0, found}, 32'd1);
`endif
    run(4'd7, 1);
    chk("clear_err", {31'd0, err}, 32'd0);
    chk("t7_result", {28'd0, result}, 32'h7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
